// File: rtl/sng_multi.sv
// Multi-channel stochastic number generator: counter ramp (MODE=0) or shared LFSR (MODE=1).
// Emits STRIDE bits per channel per enabled cycle, with start/busy/done handshake.
module sng_multi #(
  parameter int WIDTH  = 4,
  parameter int STRIDE = 1,
  parameter int NCH    = 2,
  parameter int MODE   = 0,
  parameter int SEED   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic [NCH*WIDTH-1:0]    bin_in,
  output logic                    busy,
  output logic                    sn_valid,
  output logic [NCH*STRIDE-1:0]   sn_out,
  output logic                    done
);

  // state | meaning
  // IDLE  | waiting for start; outputs quiet
  // RUN   | stream in progress; one beat per cycle with en=1
  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [11:0] taps_for(input int w);
    case (w)
      4:       return 12'h00C;
      5:       return 12'h014;
      6:       return 12'h030;
      7:       return 12'h060;
      8:       return 12'h0B8;
      9:       return 12'h110;
      10:      return 12'h240;
      11:      return 12'h500;
      12:      return 12'hE08;
      default: return 12'h000;
    endcase
  endfunction

  localparam logic [11:0]      TAPS_ALL = taps_for(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
  localparam int LAST_INT = (MODE == 0) ? (1 << WIDTH) - STRIDE : (1 << WIDTH) - 2;
  localparam logic [WIDTH-1:0] LAST_POS = LAST_INT[WIDTH-1:0];

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       pos_q, pos_d;
  logic [WIDTH-1:0]       lfsr_q, lfsr_d;
  logic [NCH*WIDTH-1:0]   op_q, op_d;

  logic                   last;
  logic                   lfsr_fb;
  logic [WIDTH-1:0]       lfsr_step;
  logic [2*WIDTH-1:0]     lfsr_dbl;
  logic [WIDTH-1:0]       op_c;
  logic [WIDTH-1:0]       rot_c;
  logic [WIDTH:0]         cmp_pos;

  assign last      = (pos_q == LAST_POS);
  assign lfsr_fb   = ^(lfsr_q & TAPS);
  assign lfsr_step = {lfsr_q[WIDTH-2:0], lfsr_fb};
  assign lfsr_dbl  = {lfsr_q, lfsr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      lfsr_q  <= WIDTH'(SEED);
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      lfsr_q  <= lfsr_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    lfsr_d  = lfsr_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pos_d   = '0;
          lfsr_d  = WIDTH'(SEED);
          op_d    = bin_in;
        end
      end
      RUN: begin
        // pos is held on the final beat; only a new start rewinds it
        if (en) begin
          lfsr_d = lfsr_step;
          if (last) state_d = IDLE;
          else      pos_d   = pos_q + WIDTH'(STRIDE);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN);
    sn_valid = 1'b0;
    done     = 1'b0;
    sn_out   = '0;
    op_c     = '0;
    rot_c    = '0;
    cmp_pos  = '0;
    if (state_q == RUN && en) begin
      sn_valid = 1'b1;
      done     = last;
      for (int c = 0; c < NCH; c++) begin
        op_c  = op_q[c*WIDTH +: WIDTH];
        rot_c = lfsr_dbl[2*WIDTH-1-(c % WIDTH) -: WIDTH];
        for (int k = 0; k < STRIDE; k++) begin
          cmp_pos = {1'b0, pos_q} + (WIDTH+1)'(k);
          if (MODE == 0) sn_out[c*STRIDE + k] = ({1'b0, op_c} > cmp_pos);
          else           sn_out[c*STRIDE + k] = (rot_c <= op_c);
        end
      end
    end
  end

endmodule

// File: tb/tb_sng_multi.sv
// Directed scoreboard bench for sng_multi across counter, wide-stride and LFSR variants.
module tb_sng_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en0, start0, busy0, v0, done0;
  logic [3:0] bin0;
  logic [0:0] sn0;
  logic       en1, start1, busy1, v1, done1;
  logic [3:0] bin1;
  logic [3:0] sn1;
  logic       en2, start2, busy2, v2, done2;
  logic [7:0] bin2;
  logic [1:0] sn2;

  sng_multi #(.WIDTH(4), .STRIDE(1), .NCH(1), .MODE(0), .SEED(1)) u_d0 (
    .clk(clk), .rst(rst), .en(en0), .start(start0), .bin_in(bin0),
    .busy(busy0), .sn_valid(v0), .sn_out(sn0), .done(done0));
  sng_multi #(.WIDTH(4), .STRIDE(4), .NCH(1), .MODE(0), .SEED(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en1), .start(start1), .bin_in(bin1),
    .busy(busy1), .sn_valid(v1), .sn_out(sn1), .done(done1));
  sng_multi #(.WIDTH(4), .STRIDE(1), .NCH(2), .MODE(1), .SEED(1)) u_d2 (
    .clk(clk), .rst(rst), .en(en2), .start(start2), .bin_in(bin2),
    .busy(busy2), .sn_valid(v2), .sn_out(sn2), .done(done2));

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  int nbeat0, nones0, first0_cyc, done0_cyc;
  int nbeat2, nones2a, nones2b;
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [4:0] q2[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_dsc0(input int op);
    logic [4:0] e;
    for (int p = 0; p < 16; p++) begin
      e = '0;
      e[0] = (op > p);
      e[4] = (p == 15);
      q0.push_back(e);
    end
  endtask

  task automatic push_lit1(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    q1.push_back({1'b0, a});
    q1.push_back({1'b0, b});
    q1.push_back({1'b0, c});
    q1.push_back({1'b1, d});
  endtask

  // reference x^4+x^3+1 LFSR from 1; channel 1 sees it rotated left by one
  task automatic push_lfsr2(input int op0, input int op1);
    logic [3:0] l;
    logic [3:0] r1;
    logic [4:0] e;
    l = 4'd1;
    for (int b = 0; b < 15; b++) begin
      r1 = {l[2:0], l[3]};
      e = '0;
      e[0] = (int'(l) <= op0);
      e[1] = (int'(r1) <= op1);
      e[4] = (b == 14);
      q2.push_back(e);
      l = {l[2:0], l[3] ^ l[2]};
    end
  endtask

  task automatic sample();
    logic [4:0] e;
    if (v0) begin
      check("d0_beat_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("d0_sn_out", 32'(sn0), 32'(e[0]));
        check("d0_done", 32'(done0), 32'(e[4]));
      end
      nbeat0++;
      nones0 += int'(sn0);
      if (nbeat0 == 1) first0_cyc = cyc_n;
      if (done0) done0_cyc = cyc_n;
    end else check("d0_quiet", 32'({done0, sn0}), 32'd0);
    if (v1) begin
      check("d1_beat_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("d1_sn_out", 32'(sn1), 32'(e[3:0]));
        check("d1_done", 32'(done1), 32'(e[4]));
      end
    end else check("d1_quiet", 32'({done1, sn1}), 32'd0);
    if (v2) begin
      check("d2_beat_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("d2_sn_out", 32'(sn2), 32'(e[1:0]));
        check("d2_done", 32'(done2), 32'(e[4]));
      end
      nbeat2++;
      nones2a += int'(sn2[0]);
      nones2b += int'(sn2[1]);
    end else check("d2_quiet", 32'({done2, sn2}), 32'd0);
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    cyc_n++;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    nbeat0 = 0; nones0 = 0; first0_cyc = -1; done0_cyc = -1;
    nbeat2 = 0; nones2a = 0; nones2b = 0;
    @(posedge clk);
    #1;
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_valid0", 32'(v0), 32'd0);
    check("rst_out0", 32'({done0, sn0}), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_out1", 32'({v1, done1, sn1}), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    check("rst_out2", 32'({v2, done2, sn2}), 32'd0);

    // rst and start together: rst wins
    bin0 = 4'd9; start0 = 1'b1;
    cyc();
    check("rst_beats_start", 32'(busy0), 32'd0);
    rst = 1'b0;

    // counter op=5 stride 1, and stride 4 op=6
    bin0 = 4'd5; start0 = 1'b1; push_dsc0(5);
    bin1 = 4'd6; start1 = 1'b1; push_lit1(4'b1111, 4'b0011, 4'b0000, 4'b0000);
    nbeat0 = 0; nones0 = 0;
    cyc();
    check("d0_busy_run", 32'(busy0), 32'd1);
    check("d1_busy_run", 32'(busy1), 32'd1);
    repeat (4) cyc();
    check("d1_busy_after_done", 32'(busy1), 32'd0);
    check("d1_q_drained", 32'(q1.size()), 32'd0);
    repeat (12) cyc();
    check("d0_busy_after_done", 32'(busy0), 32'd0);
    check("d0_q_drained", 32'(q0.size()), 32'd0);
    check("d0_ones_op5", nones0, 5);
    check("d0_beats_op5", nbeat0, 16);

    // LFSR {15,7}, plus stride-4 op=15
    bin2 = {4'd15, 4'd7}; start2 = 1'b1; push_lfsr2(7, 15);
    bin1 = 4'd15; start1 = 1'b1; push_lit1(4'b1111, 4'b1111, 4'b1111, 4'b0111);
    nbeat2 = 0; nones2a = 0; nones2b = 0;
    cyc();
    repeat (15) cyc();
    check("d2_busy_after_done", 32'(busy2), 32'd0);
    check("d2_beats", nbeat2, 15);
    check("d2_ch0_ones", nones2a, 7);
    check("d2_ch1_ones", nones2b, 15);
    check("d2_q_drained", 32'(q2.size()), 32'd0);
    check("d1_q_drained_op15", 32'(q1.size()), 32'd0);

    // LFSR boundaries back-to-back: ch0 all ones, ch1 all zeros
    bin2 = {4'd0, 4'd15}; start2 = 1'b1; push_lfsr2(15, 0);
    nbeat2 = 0; nones2a = 0; nones2b = 0;
    cyc();
    check("d2_b2b_busy", 32'(busy2), 32'd1);
    repeat (15) cyc();
    check("d2_ch0_all_ones", nones2a, 15);
    check("d2_ch1_all_zero", nones2b, 0);
    check("d2_busy_end", 32'(busy2), 32'd0);

    // stall: en low for 3 cycles at beat 6
    bin0 = 4'd9; start0 = 1'b1; push_dsc0(9);
    nbeat0 = 0; nones0 = 0; first0_cyc = -1; done0_cyc = -1;
    cyc();
    repeat (5) cyc();
    en0 = 1'b0;
    #1;
    check("stall_valid_low", 32'(v0), 32'd0);
    repeat (3) begin
      check("stall_busy_held", 32'(busy0), 32'd1);
      cyc();
    end
    en0 = 1'b1;
    for (int i = 0; i < 30 && busy0; i++) cyc();
    check("stall_terminates", 32'(busy0), 32'd0);
    check("stall_span", done0_cyc - first0_cyc + 1, 19);
    check("stall_beats", nbeat0, 16);
    check("stall_ones", nones0, 9);
    check("stall_q_drained", 32'(q0.size()), 32'd0);

    // reset at beat 8 aborts without done
    bin0 = 4'd10; start0 = 1'b1; push_dsc0(10);
    nbeat0 = 0; done0_cyc = -1;
    cyc();
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q0.delete();
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_valid", 32'(v0), 32'd0);
    check("abort_out", 32'(sn0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    check("abort_no_done_seen", done0_cyc, -1);
    check("abort_beats", nbeat0, 8);
    bin0 = 4'd3; start0 = 1'b1; push_dsc0(3);
    nones0 = 0; nbeat0 = 0;
    cyc();
    repeat (16) cyc();
    check("after_abort_ones", nones0, 3);
    check("after_abort_busy", 32'(busy0), 32'd0);

    // start and bin_in changes during RUN are ignored
    bin0 = 4'd2; start0 = 1'b1; push_dsc0(2);
    nones0 = 0;
    cyc();
    repeat (3) cyc();
    start0 = 1'b1; bin0 = 4'd12;
    cyc();
    check("ignore_start_busy", 32'(busy0), 32'd1);
    repeat (12) cyc();
    check("ignore_start_done", 32'(busy0), 32'd0);
    check("ignore_start_ones", nones0, 2);
    start0 = 1'b1; push_dsc0(12);
    nones0 = 0;
    cyc();
    check("b2b_start_accepted", 32'(busy0), 32'd1);
    repeat (16) cyc();
    check("b2b_ones", nones0, 12);
    check("b2b_busy_end", 32'(busy0), 32'd0);
    check("b2b_q_drained", 32'(q0.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
